// File: rtl/resp_demux2.sv
// Registered 1-to-2 response router: one valid/ready stream steered per beat by
// in_sel into one of two independent output FIFOs, each with its own consumer.
module resp_demux2_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              ready_i,
    output logic              full_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CW-1:0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [AW-1:0]                wptr_q, wptr_d;
    logic [AW-1:0]                rptr_q, rptr_d;
    logic [CW-1:0]                count_q, count_d;
    logic                         pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign pop     = valid_o & ready_i;
    assign data_o  = valid_o ? mem_q[rptr_q] : '0;
    assign count_o = count_q;

    // Pointers wrap naturally since DEPTH is a power of two; only the count
    // tells full from empty.
    always_comb begin
        wptr_d  = push_i ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop    ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        case ({push_i, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end
endmodule

module resp_demux2 #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 2,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic [CW-1:0]     out0_count,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic [CW-1:0]     out1_count
);
    logic [1:0]             push, full, valid, ready;
    logic [1:0][DATA_W-1:0] data;
    logic [1:0][CW-1:0]     count;

    // Ready depends only on the selected port's occupancy, so a stalled port
    // never holds back beats bound for the other one.
    assign in_ready = ~full[in_sel];
    assign push[0]  = in_valid & in_ready & ~in_sel;
    assign push[1]  = in_valid & in_ready &  in_sel;
    assign ready    = {out1_ready, out0_ready};

    for (genvar p = 0; p < 2; p++) begin : g_port
        resp_demux2_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CW(CW)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[p]),
            .wdata_i (in_data),
            .ready_i (ready[p]),
            .full_o  (full[p]),
            .valid_o (valid[p]),
            .data_o  (data[p]),
            .count_o (count[p])
        );
    end

    assign out0_valid = valid[0];
    assign out0_data  = data[0];
    assign out0_count = count[0];
    assign out1_valid = valid[1];
    assign out1_data  = data[1];
    assign out1_count = count[1];
endmodule
